counter_seq: RTL and testbench
==============================

# counter_seq

Sequencer that configures and runs the bounded wrap-around counter. It accepts a job (lower bound, upper bound, wrap count) over a valid/ready handshake and rejects malformed jobs. It then drives the counter's bounds and reset, counts wraps by watching the counter output, and signals completion. It sits between a software/config master and one counter instance, and owns that counter's reset exclusively.

## Interface
- DATA_WIDTH, 32, width of bounds and counter value
- WRAP_WIDTH, 16, width of requested/observed wrap count
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  job request valid
- cfg_ready  out  1  high only in IDLE
- cfg_lower  in  DATA_WIDTH  requested lower bound
- cfg_upper  in  DATA_WIDTH  requested upper bound
- cfg_wraps  in  WRAP_WIDTH  number of wraps to run (N)
- abort  in  1  stop current job (effective only with ABORT_EN)
- ctr_lower_bound  out  DATA_WIDTH  to counter lower_bound
- ctr_upper_bound  out  DATA_WIDTH  to counter upper_bound
- ctr_rst  out  1  to counter rst (synchronous, active-high)
- ctr_out  in  DATA_WIDTH  counter output
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse on job completion
- err  out  1  one-cycle pulse on rejected job
- wrap_count  out  WRAP_WIDTH  wraps observed in current/last job

## Operation
- Counter contract: on an edge with ctr_rst=1, out becomes lower_bound. Otherwise, if out==upper_bound, out becomes lower_bound; else out+1.
- State is registered. States are IDLE, LOAD, RUN and DONE. Reset enters IDLE.
- Reset values: cfg_ready=1 and ctr_rst=1. All other outputs are 0, including both bounds and wrap_count.
- IDLE: cfg_ready=1, ctr_rst=1. On cfg_valid&&cfg_ready:
  - Reject if cfg_lower>cfg_upper or cfg_wraps==0: err=1 next cycle, stay IDLE, no register changes.
  - Otherwise latch lower, upper and N into registers, clear wrap_count, go to LOAD.
- LOAD (1 cycle): ctr_rst=1, bounds driven from the latched registers. Go to RUN.
- RUN: ctr_rst=0. Each cycle with ctr_out==upper counts as a wrap, and wrap_count increments at the edge.
  - If the wrap being counted makes wrap_count==N, go to DONE.
- DONE (1 cycle): done=1, ctr_rst=1. Go to IDLE.
- Bounds hold their latched values through IDLE until the next accepted job.
- wrap_count holds its value until the next accepted job.
- Arithmetic: compare and increment are unsigned. wrap_count never exceeds N, so it cannot overflow.
- Edge case lower==upper (range R=1): every RUN cycle is a wrap.

## Timing
- Let accept edge = t0 and R = upper-lower+1.
- LOAD occupies cycle t0..t0+1. ctr_out=lower from the t0+1 edge.
- RUN cycle k (k=0 at t0+1) sees ctr_out = lower + (k mod R).
- Wraps are detected at RUN cycles R-1, 2R-1, …, N·R-1.
- done is high in the cycle after the last wrap, i.e. t0+1+N·R.
- cfg_ready returns one cycle after that.
- Total job latency, accept to done: N·R+1 cycles. Back-to-back jobs have a minimum gap of 1 IDLE cycle.
- err rises the cycle after the rejecting handshake and lasts exactly 1 cycle.
- rst asserted in any state takes effect at the next edge: IDLE, reset values, no done/err pulse. An in-flight job is lost.
- cfg_valid while not in IDLE is ignored; it is not queued.

## Configuration
- ABORT_EN defined:
  - abort=1 in LOAD or RUN returns to IDLE at the next edge. ctr_rst=1 from that cycle, done is not pulsed, wrap_count holds its partial value.
  - abort in IDLE or DONE has no effect.
  - abort coinciding with the final wrap: abort wins, so no done.
- ABORT_EN undefined: the abort port exists but is ignored, and jobs end only via completion or rst.

## Test plan
- Reset then job lower=3, upper=10, N=2: done exactly 17 cycles after accept, wrap_count=2, ctr_out=3 after done, cfg_ready back next cycle.
- lower=5, upper=5, N=4: done 5 cycles after accept, wrap_count=4, ctr_rst low for exactly 4 cycles.
- lower=10, upper=3, N=1, and separately N=0: err pulses 1 cycle, state stays IDLE, busy=0, bounds keep their previous values.
- Job 3..10, N=2, with rst asserted at RUN cycle 11: next cycle all outputs at reset values, no done. A following job runs normally.
- ABORT_EN on, job 3..10, N=2, abort at RUN cycle 11: IDLE next cycle, wrap_count=1, no done, ctr_out=3 one edge later. With ABORT_EN off, the same stimulus gives done at 17.
- cfg_valid held high through a whole job: a second job is accepted only in the IDLE cycle after done, with no acceptance during LOAD, RUN or DONE.

Source files
------------

// File: rtl/counter_seq.sv
// counter_seq: accepts counter jobs over valid/ready, runs a bounded counter for N wraps, pulses done or err.
// Ports: clk, rst (sync, active-high); cfg_valid/cfg_ready/cfg_lower/cfg_upper/cfg_wraps job handshake;
// abort (honoured only when ABORT_EN is defined); ctr_lower_bound/ctr_upper_bound/ctr_rst drive the counter,
// ctr_out observes it; busy, done, err, wrap_count report status.
module counter_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int WRAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_lower,
  input  logic [DATA_WIDTH-1:0] cfg_upper,
  input  logic [WRAP_WIDTH-1:0] cfg_wraps,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] ctr_lower_bound,
  output logic [DATA_WIDTH-1:0] ctr_upper_bound,
  output logic                  ctr_rst,
  input  logic [DATA_WIDTH-1:0] ctr_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WRAP_WIDTH-1:0] wrap_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q;
  logic [DATA_WIDTH-1:0] lower_q, upper_q;
  logic [WRAP_WIDTH-1:0] n_q, wrap_q, wrap_d;
  logic err_q, accept, bad, wrap_hit, stop;
  assign accept   = cfg_valid && state_q == IDLE;
  assign bad      = cfg_lower > cfg_upper || cfg_wraps == '0;
  assign wrap_hit = state_q == RUN && ctr_out == upper_q;
  assign wrap_d   = wrap_q + 1'b1;
`ifdef ABORT_EN
  // abort on the final wrap still wins, so neither done nor the last increment happen
  assign stop = abort && (state_q == LOAD || state_q == RUN);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign stop = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lower_q <= '0;
      upper_q <= '0;
      n_q     <= '0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && bad;
      if (stop) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE: if (accept && !bad) begin
            state_q <= LOAD;
            lower_q <= cfg_lower;
            upper_q <= cfg_upper;
            n_q     <= cfg_wraps;
            wrap_q  <= '0;
          end
          LOAD: state_q <= RUN;
          RUN: if (wrap_hit) begin
            wrap_q <= wrap_d;
            if (wrap_d == n_q) state_q <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign cfg_ready       = state_q == IDLE;
  assign ctr_rst         = state_q != RUN;
  assign busy            = state_q == LOAD || state_q == RUN;
  assign done            = state_q == DONE;
  assign err             = err_q;
  assign wrap_count      = wrap_q;
  assign ctr_lower_bound = lower_q;
  assign ctr_upper_bound = upper_q;
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: table-driven job vectors with a scoreboard queue, plus reset/abort/held-valid sequences.
module tb_counter_seq;
  localparam int DW = 32;
  localparam int WW = 16;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, abort = 1'b0;
  logic [DW-1:0] cfg_lower = '0, cfg_upper = '0;
  logic [WW-1:0] cfg_wraps = '0;
  logic cfg_ready, ctr_rst, busy, done, err;
  logic [DW-1:0] ctr_lower_bound, ctr_upper_bound;
  logic [DW-1:0] ctr_out = '0;
  logic [WW-1:0] wrap_count;
  int cyc = 0;
  int total = 0, passed = 0;
  counter_seq #(.DATA_WIDTH(DW), .WRAP_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_wraps(cfg_wraps), .abort(abort),
    .ctr_lower_bound(ctr_lower_bound), .ctr_upper_bound(ctr_upper_bound), .ctr_rst(ctr_rst),
    .ctr_out(ctr_out), .busy(busy), .done(done), .err(err), .wrap_count(wrap_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    ctr_out <= (ctr_rst || ctr_out == ctr_upper_bound) ? ctr_lower_bound : ctr_out + 1;
  typedef struct {int unsigned lo; int unsigned hi; int n;} vec_t;
  typedef struct {bit is_err; int lat; int wraps; int unsigned lo; int unsigned hi; int runs;} exp_t;
  vec_t vecs[6];
  exp_t sb[$];
  int unsigned prev_lo = 0, prev_hi = 0;
  int prev_wraps = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic wait_ready();
    for (int k = 0; k < 100 && !cfg_ready; k++) @(negedge clk);
    chk("ready_before_job", cfg_ready, 1);
  endtask
  task automatic start_job(input int unsigned lo, input int unsigned hi, input int n, output int t0);
    wait_ready();
    cfg_lower = lo; cfg_upper = hi; cfg_wraps = WW'(n); cfg_valid = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic do_job(input int unsigned lo, input int unsigned hi, input int n);
    exp_t e;
    int t0, runs;
    e.is_err = lo > hi || n == 0;
    e.runs   = e.is_err ? 0 : n * int'(hi - lo + 1);
    e.lat    = e.is_err ? 0 : e.runs + 1;
    e.wraps  = e.is_err ? prev_wraps : n;
    e.lo     = e.is_err ? prev_lo : lo;
    e.hi     = e.is_err ? prev_hi : hi;
    sb.push_back(e);
    start_job(lo, hi, n, t0);
    runs = 0;
    for (int k = 0; k < 3000 && !done && !err; k++) begin
      if (!ctr_rst) runs++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("end_err", err, e.is_err);
    chk("end_done", done, !e.is_err);
    chk("latency", cyc - t0, e.lat);
    chk("wrap_count", wrap_count, e.wraps);
    chk("lower_bound", ctr_lower_bound, e.lo);
    chk("upper_bound", ctr_upper_bound, e.hi);
    chk("run_cycles", runs, e.runs);
    if (e.is_err) chk("busy_on_err", busy, 0);
    @(negedge clk);
    chk("pulse_one_cycle", done | err, 0);
    chk("ready_after", cfg_ready, 1);
    if (!e.is_err) chk("ctr_out_after_done", ctr_out, lo);
    prev_lo = e.lo; prev_hi = e.hi; prev_wraps = e.wraps;
  endtask
  initial begin
    int t0;
    bit saw_done;
    int acc[$];
    vecs[0] = '{3, 10, 2};
    vecs[1] = '{5, 5, 4};
    vecs[2] = '{10, 3, 1};
    vecs[3] = '{10, 3, 0};
    vecs[4] = '{2, 6, 0};
    vecs[5] = '{0, 2, 3};
    repeat (3) @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_ctr_rst", ctr_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lower", ctr_lower_bound, 0);
    chk("rst_upper", ctr_upper_bound, 0);
    chk("rst_wraps", wrap_count, 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) do_job(vecs[i].lo, vecs[i].hi, vecs[i].n);
    start_job(3, 10, 2, t0);
    saw_done = 1'b0;
    for (int k = 0; k < 100 && cyc < t0 + 12; k++) begin
      saw_done |= done;
      @(negedge clk);
    end
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_no_done", saw_done | done, 0);
    chk("rst_mid_ready", cfg_ready, 1);
    chk("rst_mid_ctr_rst", ctr_rst, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_lower", ctr_lower_bound, 0);
    chk("rst_mid_upper", ctr_upper_bound, 0);
    chk("rst_mid_wraps", wrap_count, 0);
    prev_lo = 0; prev_hi = 0; prev_wraps = 0;
    do_job(0, 4, 2);
    start_job(3, 10, 2, t0);
    for (int k = 0; k < 100 && cyc < t0 + 12; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`ifdef ABORT_EN
    chk("abort_ready", cfg_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ctr_rst", ctr_rst, 1);
    chk("abort_wraps", wrap_count, 1);
    @(negedge clk);
    chk("abort_ctr_out", ctr_out, 3);
    prev_wraps = 1;
`else
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    chk("noabort_done", done, 1);
    chk("noabort_latency", cyc - t0, 17);
    chk("noabort_wraps", wrap_count, 2);
    @(negedge clk);
    prev_wraps = 2;
`endif
    prev_lo = 3; prev_hi = 10;
    wait_ready();
    cfg_lower = 2; cfg_upper = 4; cfg_wraps = 2; cfg_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (cfg_ready) acc.push_back(cyc + 1);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk("held_accept_count", acc.size(), 4);
    if (acc.size() >= 3) begin
      chk("held_gap1", acc[1] - acc[0], 9);
      chk("held_gap2", acc[2] - acc[1], 9);
    end
    wait_ready();
    @(negedge clk);
    chk("held_final_wraps", wrap_count, 2);
    prev_lo = 2; prev_hi = 4; prev_wraps = 2;
    do_job(7, 8, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
